wb_buffer: RTL and testbench

- Writeback-side counterpart of the operand-read path.
- Accepts results from NUM_SRC functional-unit lanes over valid/ready and queues each lane in its own DEPTH-entry FIFO.
- Drives one vector register file write port per lane.
- When lane heads target the same register-file bank, a round-robin arbiter serializes them. Losing lanes hold their heads and back-pressure their producers.

---
 rtl/wb_buffer.sv | 146 ++++++++++++++
 tb/tb_wb_buffer.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_buffer.sv
// Writeback buffer: per-lane result FIFOs feeding one register file write port each.
// Same-bank heads are serialized by a round-robin arbiter; losers hold and back-pressure.
module wb_buffer #(
   parameter int NUM_SRC   = 2,
   parameter int DEPTH     = 2,
   parameter int DATA_W    = 512,
   parameter int MASK_W    = 32,
   parameter int REG_W     = 5,
   parameter int NUM_BANKS = 4
) (
   input  logic                                  CLK,
   input  logic                                  nRST,
   input  logic                                  flush,
   input  logic [NUM_SRC-1:0]                    in_valid,
   output logic [NUM_SRC-1:0]                    in_ready,
   input  logic [NUM_SRC*REG_W-1:0]              in_vd,
   input  logic [NUM_SRC*DATA_W-1:0]             in_data,
   input  logic [NUM_SRC*MASK_W-1:0]             in_mask,
   output logic [NUM_SRC-1:0]                    wr_en,
   input  logic [NUM_SRC-1:0]                    wr_ready,
   output logic [NUM_SRC*REG_W-1:0]              wr_vd,
   output logic [NUM_SRC*DATA_W-1:0]             wr_data,
   output logic [NUM_SRC*MASK_W-1:0]             wr_mask,
   output logic [NUM_SRC*($clog2(DEPTH)+1)-1:0]  lane_count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int RW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

   logic [REG_W-1:0]  vd_q   [NUM_SRC][DEPTH];
   logic [DATA_W-1:0] data_q [NUM_SRC][DEPTH];
   logic [MASK_W-1:0] mask_q [NUM_SRC][DEPTH];
   logic [PW-1:0]     head_q [NUM_SRC];
   logic [PW-1:0]     tail_q [NUM_SRC];
   logic [CW-1:0]     cnt_q  [NUM_SRC];
   logic [RW-1:0]     rr_q;
   logic [RW-1:0]     rr_d;

   logic [NUM_SRC-1:0] cand;
   logic [NUM_SRC-1:0] push;
   logic [NUM_SRC-1:0] pop;
   logic [REG_W-1:0]   hvd [NUM_SRC];
   logic               blocked;
   logic               beats;
   int                 win;
   int                 winpos;
   int                 pi;

   function automatic int bank_of(input logic [REG_W-1:0] v);
      return int'(v) % NUM_BANKS;
   endfunction

   function automatic int pos_of(input int i, input int rr);
      return (i + NUM_SRC - rr) % NUM_SRC;
   endfunction

   always_comb begin
      for (int i = 0; i < NUM_SRC; i++) begin
         in_ready[i] = cnt_q[i] < CW'(DEPTH);
         cand[i]     = (cnt_q[i] != '0) && !flush;
         hvd[i]      = (cnt_q[i] != '0) ? vd_q[i][head_q[i]] : '0;
         wr_vd[i*REG_W +: REG_W] = hvd[i];
         wr_data[i*DATA_W +: DATA_W] =
            (cnt_q[i] != '0) ? data_q[i][head_q[i]] : '0;
         wr_mask[i*MASK_W +: MASK_W] =
            (cnt_q[i] != '0) ? mask_q[i][head_q[i]] : '0;
         lane_count[i*CW +: CW] = cnt_q[i];
      end
   end

   // Winner tracking keeps the conflict winner latest in priority order.
   always_comb begin
      wr_en   = '0;
      win     = 0;
      winpos  = -1;
      pi      = 0;
      blocked = 1'b0;
      beats   = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         pi      = pos_of(i, int'(rr_q));
         blocked = 1'b0;
         beats   = 1'b0;
         for (int j = 0; j < NUM_SRC; j++) begin
            if (j != i && cand[j] &&
                bank_of(hvd[j]) == bank_of(hvd[i])) begin
               if (pos_of(j, int'(rr_q)) < pi) blocked = 1'b1;
               else                            beats   = 1'b1;
            end
         end
         wr_en[i] = cand[i] && !blocked;
         if (wr_en[i] && beats && pi > winpos) begin
            winpos = pi;
            win    = i;
         end
      end
   end

   always_comb begin
      push = in_valid & in_ready & {NUM_SRC{!flush}};
      pop  = wr_en & wr_ready;
      rr_d = rr_q;
      if (winpos >= 0 && pop[win])
         rr_d = RW'((win + 1) % NUM_SRC);
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         rr_q <= '0;
         for (int i = 0; i < NUM_SRC; i++) begin
            head_q[i] <= '0;
            tail_q[i] <= '0;
            cnt_q[i]  <= '0;
            for (int k = 0; k < DEPTH; k++) begin
               vd_q[i][k]   <= '0;
               data_q[i][k] <= '0;
               mask_q[i][k] <= '0;
            end
         end
      end else if (flush) begin
         rr_q <= '0;
         for (int i = 0; i < NUM_SRC; i++) begin
            head_q[i] <= '0;
            tail_q[i] <= '0;
            cnt_q[i]  <= '0;
         end
      end else begin
         rr_q <= rr_d;
         for (int i = 0; i < NUM_SRC; i++) begin
            if (push[i]) begin
               vd_q[i][tail_q[i]]   <= in_vd[i*REG_W +: REG_W];
               data_q[i][tail_q[i]] <= in_data[i*DATA_W +: DATA_W];
               mask_q[i][tail_q[i]] <= in_mask[i*MASK_W +: MASK_W];
               tail_q[i]            <= tail_q[i] + PW'(1);
            end
            if (pop[i])
               head_q[i] <= head_q[i] + PW'(1);
            if (push[i] && !pop[i])
               cnt_q[i] <= cnt_q[i] + CW'(1);
            else if (!push[i] && pop[i])
               cnt_q[i] <= cnt_q[i] - CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_wb_buffer.sv
// Directed bench for wb_buffer: FIFO order, bank arbitration, back-pressure,
// flush and asynchronous reset.
module tb_wb_buffer;

   logic          CLK = 1'b0;
   logic          nRST = 1'b0;
   logic          flush = 1'b0;
   logic [1:0]    in_valid = '0;
   logic [1:0]    in_ready;
   logic [9:0]    in_vd = '0;
   logic [1023:0] in_data = '0;
   logic [63:0]   in_mask = '0;
   logic [1:0]    wr_en;
   logic [1:0]    wr_ready = '0;
   logic [9:0]    wr_vd;
   logic [1023:0] wr_data;
   logic [63:0]   wr_mask;
   logic [3:0]    lane_count;

   int total = 0;
   int bad = 0;

   wb_buffer dut (
      .CLK(CLK), .nRST(nRST), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_vd(in_vd), .in_data(in_data), .in_mask(in_mask),
      .wr_en(wr_en), .wr_ready(wr_ready),
      .wr_vd(wr_vd), .wr_data(wr_data), .wr_mask(wr_mask),
      .lane_count(lane_count)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic set_lane(input int l, input logic [4:0] vd,
                           input logic [511:0] d, input logic [31:0] m);
      in_vd[l*5 +: 5]       = vd;
      in_data[l*512 +: 512] = d;
      in_mask[l*32 +: 32]   = m;
   endtask

   task automatic test_reset();
      nRST = 1'b0;
      #12;
      total++;
      if (wr_en !== 2'b00) begin
         bad++; $display("FAIL rst_wr_en got=%b want=00", wr_en);
      end
      total++;
      if (in_ready !== 2'b11) begin
         bad++; $display("FAIL rst_in_ready got=%b want=11", in_ready);
      end
      total++;
      if (lane_count !== 4'h0 || wr_vd !== 10'h0 || wr_mask !== 64'h0) begin
         bad++;
         $display("FAIL rst_outs cnt=%h vd=%h mask=%h want 0", lane_count, wr_vd, wr_mask);
      end
      total++;
      if (wr_data !== 1024'h0) begin
         bad++; $display("FAIL rst_wr_data got nonzero want 0");
      end
      @(posedge CLK);
      #1 nRST = 1'b1;
   endtask

   task automatic test_single();
      wr_ready = 2'b11;
      set_lane(0, 5'd3, 512'hA, 32'hFFFF_FFFF);
      in_valid = 2'b01;
      #2;
      total++;
      if (wr_en !== 2'b00) begin
         bad++; $display("FAIL single_no_bypass got=%b want=00", wr_en);
      end
      tick();
      in_valid = 2'b00;
      #2;
      total++;
      if (wr_en !== 2'b01 || wr_vd[4:0] !== 5'd3) begin
         bad++; $display("FAIL single_head en=%b vd=%0d want en=01 vd=3", wr_en, wr_vd[4:0]);
      end
      total++;
      if (wr_data[511:0] !== 512'hA || wr_mask[31:0] !== 32'hFFFF_FFFF) begin
         bad++;
         $display("FAIL single_data data=%h mask=%h want A/FFFFFFFF", wr_data[511:0], wr_mask[31:0]);
      end
      total++;
      if (lane_count !== 4'h1) begin
         bad++; $display("FAIL single_cnt got=%h want=1", lane_count);
      end
      tick();
      #2;
      total++;
      if (lane_count !== 4'h0 || wr_en !== 2'b00 || wr_vd !== 10'h0) begin
         bad++;
         $display("FAIL single_pop cnt=%h en=%b vd=%h want 0", lane_count, wr_en, wr_vd);
      end
   endtask

   task automatic test_no_conflict();
      wr_ready = 2'b11;
      set_lane(0, 5'd2, 512'hB, 32'h1);
      set_lane(1, 5'd7, 512'hC, 32'h2);
      in_valid = 2'b11;
      tick();
      in_valid = 2'b00;
      #2;
      total++;
      if (wr_en !== 2'b11) begin
         bad++; $display("FAIL nc_wr_en got=%b want=11", wr_en);
      end
      total++;
      if (wr_data[1023:512] !== 512'hC || wr_vd[9:5] !== 5'd7) begin
         bad++; $display("FAIL nc_lane1 vd=%0d data=%h want 7/C", wr_vd[9:5], wr_data[1023:512]);
      end
      tick();
      #2;
      total++;
      if (lane_count !== 4'h0 || dut.rr_q !== 1'b0) begin
         bad++; $display("FAIL nc_after cnt=%h rr=%0d want 0/0", lane_count, dut.rr_q);
      end
   endtask

   task automatic test_conflict();
      wr_ready = 2'b00;
      set_lane(0, 5'd1, 512'hD, 32'h3);
      set_lane(1, 5'd5, 512'hE, 32'h4);
      in_valid = 2'b11;
      tick();
      in_valid = 2'b00;
      #2;
      total++;
      if (wr_en !== 2'b01) begin
         bad++; $display("FAIL cf_first got=%b want=01", wr_en);
      end
      tick();
      #2;
      total++;
      if (wr_en !== 2'b01 || dut.rr_q !== 1'b0 || lane_count !== 4'h5) begin
         bad++;
         $display("FAIL cf_stall en=%b rr=%0d cnt=%h want 01/0/5", wr_en, dut.rr_q, lane_count);
      end
      wr_ready = 2'b11;
      tick();
      #2;
      total++;
      if (wr_en !== 2'b10 || dut.rr_q !== 1'b1 || wr_vd[9:5] !== 5'd5) begin
         bad++;
         $display("FAIL cf_second en=%b rr=%0d vd=%0d want 10/1/5", wr_en, dut.rr_q, wr_vd[9:5]);
      end
      tick();
      #2;
      total++;
      if (wr_en !== 2'b00 || dut.rr_q !== 1'b1) begin
         bad++; $display("FAIL cf_hold en=%b rr=%0d want 00/1", wr_en, dut.rr_q);
      end
      set_lane(0, 5'd1, 512'hF, 32'h5);
      set_lane(1, 5'd9, 512'h10, 32'h6);
      in_valid = 2'b11;
      tick();
      in_valid = 2'b00;
      #2;
      total++;
      if (wr_en !== 2'b10) begin
         bad++; $display("FAIL cf_rr1_first got=%b want=10", wr_en);
      end
      tick();
      #2;
      total++;
      if (wr_en !== 2'b01 || dut.rr_q !== 1'b0 || wr_data[511:0] !== 512'hF) begin
         bad++; $display("FAIL cf_rr1_second en=%b rr=%0d want 01/0", wr_en, dut.rr_q);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      wr_ready = 2'b10;
      set_lane(0, 5'd4, 512'h100, 32'hA);
      in_valid = 2'b01;
      tick();
      set_lane(0, 5'd4, 512'h101, 32'hB);
      #2;
      total++;
      if (in_ready[0] !== 1'b1 || wr_data[511:0] !== 512'h100) begin
         bad++; $display("FAIL bp_one rdy=%b data=%h want 1/100", in_ready[0], wr_data[511:0]);
      end
      tick();
      set_lane(0, 5'd4, 512'h102, 32'hC);
      #2;
      total++;
      if (in_ready[0] !== 1'b0 || lane_count[1:0] !== 2'd2) begin
         bad++; $display("FAIL bp_full rdy=%b cnt=%0d want 0/2", in_ready[0], lane_count[1:0]);
      end
      tick();
      #2;
      total++;
      if (lane_count[1:0] !== 2'd2 || wr_data[511:0] !== 512'h100 ||
          wr_mask[31:0] !== 32'hA || wr_en[0] !== 1'b1) begin
         bad++;
         $display("FAIL bp_stable cnt=%0d data=%h en=%b want 2/100/1", lane_count[1:0], wr_data[511:0], wr_en[0]);
      end
      wr_ready = 2'b11;
      tick();
      #2;
      total++;
      if (wr_data[511:0] !== 512'h101 || lane_count[1:0] !== 2'd1 || in_ready[0] !== 1'b1) begin
         bad++;
         $display("FAIL bp_drain1 data=%h cnt=%0d rdy=%b want 101/1/1", wr_data[511:0], lane_count[1:0], in_ready[0]);
      end
      tick();
      in_valid = 2'b00;
      #2;
      total++;
      if (wr_data[511:0] !== 512'h102 || lane_count[1:0] !== 2'd1 || wr_mask[31:0] !== 32'hC) begin
         bad++; $display("FAIL bp_drain2 data=%h cnt=%0d want 102/1", wr_data[511:0], lane_count[1:0]);
      end
      tick();
      #2;
      total++;
      if (lane_count !== 4'h0) begin
         bad++; $display("FAIL bp_empty cnt=%h want 0", lane_count);
      end
   endtask

   task automatic test_push_pop_wrap();
      logic [511:0] exp_d;
      wr_ready = 2'b11;
      set_lane(0, 5'd0, 512'h200, 32'h0);
      in_valid = 2'b01;
      tick();
      for (int k = 1; k <= 6; k++) begin
         set_lane(0, 5'(k), 512'h200 + 512'(k), 32'(k));
         exp_d = 512'h200 + 512'(k - 1);
         #2;
         total++;
         if (lane_count[1:0] !== 2'd1 || wr_data[511:0] !== exp_d ||
             wr_vd[4:0] !== 5'(k - 1)) begin
            bad++;
            $display("FAIL wrap_%0d cnt=%0d data=%h want 1/%h", k, lane_count[1:0], wr_data[511:0], exp_d);
         end
         tick();
      end
      in_valid = 2'b00;
      #2;
      total++;
      if (wr_data[511:0] !== 512'h206 || lane_count[1:0] !== 2'd1) begin
         bad++; $display("FAIL wrap_last data=%h want 206", wr_data[511:0]);
      end
      tick();
   endtask

   task automatic test_flush();
      wr_ready = 2'b11;
      set_lane(0, 5'd1, 512'h300, 32'h0);
      set_lane(1, 5'd5, 512'h301, 32'h0);
      in_valid = 2'b11;
      tick();
      in_valid = 2'b00;
      tick();
      tick();
      wr_ready = 2'b00;
      in_valid = 2'b11;
      set_lane(0, 5'd2, 512'h310, 32'h0);
      set_lane(1, 5'd3, 512'h311, 32'h0);
      tick();
      set_lane(0, 5'd2, 512'h312, 32'h0);
      set_lane(1, 5'd3, 512'h313, 32'h0);
      tick();
      in_valid = 2'b00;
      #2;
      total++;
      if (lane_count !== 4'hA || dut.rr_q !== 1'b1) begin
         bad++; $display("FAIL fl_pre cnt=%h rr=%0d want A/1", lane_count, dut.rr_q);
      end
      flush = 1'b1;
      wr_ready = 2'b11;
      in_valid = 2'b11;
      set_lane(0, 5'd6, 512'hDEAD, 32'h0);
      set_lane(1, 5'd6, 512'hDEAD, 32'h0);
      #1;
      total++;
      if (wr_en !== 2'b00) begin
         bad++; $display("FAIL fl_wr_en got=%b want=00", wr_en);
      end
      tick();
      flush = 1'b0;
      in_valid = 2'b00;
      #2;
      total++;
      if (lane_count !== 4'h0 || in_ready !== 2'b11 || dut.rr_q !== 1'b0 || wr_en !== 2'b00) begin
         bad++;
         $display("FAIL fl_after cnt=%h rdy=%b rr=%0d en=%b want 0/11/0/00", lane_count, in_ready, dut.rr_q, wr_en);
      end
      wr_ready = 2'b00;
      set_lane(1, 5'd6, 512'h320, 32'h0);
      in_valid = 2'b10;
      tick();
      flush = 1'b1;
      set_lane(1, 5'd6, 512'hBEEF, 32'h0);
      #2;
      total++;
      if (in_ready[1] !== 1'b1 || wr_en !== 2'b00) begin
         bad++; $display("FAIL fl_push_cycle rdy=%b en=%b want 1/00", in_ready[1], wr_en);
      end
      tick();
      flush = 1'b0;
      in_valid = 2'b00;
      wr_ready = 2'b11;
      #2;
      total++;
      if (lane_count !== 4'h0 || wr_en !== 2'b00 || wr_data !== 1024'h0) begin
         bad++; $display("FAIL fl_discard cnt=%h en=%b want 0/00", lane_count, wr_en);
      end
      tick();
      #2;
      total++;
      if (wr_en !== 2'b00) begin
         bad++; $display("FAIL fl_never_written en=%b want 00", wr_en);
      end
   endtask

   task automatic test_async_reset();
      wr_ready = 2'b00;
      set_lane(0, 5'd3, 512'h400, 32'h7);
      in_valid = 2'b01;
      tick();
      in_valid = 2'b00;
      #2;
      total++;
      if (lane_count[1:0] !== 2'd1 || wr_en !== 2'b01) begin
         bad++; $display("FAIL ar_pre cnt=%0d en=%b want 1/01", lane_count[1:0], wr_en);
      end
      nRST = 1'b0;
      #1;
      total++;
      if (wr_en !== 2'b00 || lane_count !== 4'h0 || in_ready !== 2'b11 ||
          wr_data !== 1024'h0 || wr_vd !== 10'h0) begin
         bad++;
         $display("FAIL ar_outs en=%b cnt=%h rdy=%b want 00/0/11", wr_en, lane_count, in_ready);
      end
      @(posedge CLK);
      #1 nRST = 1'b1;
      #2;
      total++;
      if (lane_count !== 4'h0 || dut.rr_q !== 1'b0) begin
         bad++; $display("FAIL ar_after cnt=%h rr=%0d want 0/0", lane_count, dut.rr_q);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_no_conflict();
      test_conflict();
      test_back_to_back();
      test_push_pop_wrap();
      test_flush();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
